// File: rtl/regfile_param_if.sv
// Register file port bundle: one write port, a busy-mark port, two read ports
// and the scoreboard status outputs.
interface regfile_param_if #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5
);
    logic                 we;
    logic [ADDR_BITS-1:0] waddr;
    logic [WIDTH-1:0]     wdata;
    logic                 mark_en;
    logic [ADDR_BITS-1:0] mark_addr;
    logic [ADDR_BITS-1:0] raddr_a;
    logic [ADDR_BITS-1:0] raddr_b;
    logic [WIDTH-1:0]     rdata_a;
    logic [WIDTH-1:0]     rdata_b;
    logic                 busy_a;
    logic                 busy_b;
    logic                 any_busy;

    modport master (
        output we, waddr, wdata, mark_en, mark_addr, raddr_a, raddr_b,
        input  rdata_a, rdata_b, busy_a, busy_b, any_busy
    );

    modport slave (
        input  we, waddr, wdata, mark_en, mark_addr, raddr_a, raddr_b,
        output rdata_a, rdata_b, busy_a, busy_b, any_busy
    );
endinterface

// File: rtl/regfile_param.sv
// DEPTH x WIDTH register file with entry 0 tied to zero, two combinational
// read ports, optional write-to-read bypass and a per-entry busy scoreboard.
module regfile_param #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int BYPASS    = 1
) (
    input  logic             clk,
    input  logic             clr,
    regfile_param_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int NPORT = 2;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [DEPTH-1:0]            busy;

    logic wr_hit;
    logic mk_hit;
    assign wr_hit = bus.we      && (bus.waddr     != '0);
    assign mk_hit = bus.mark_en && (bus.mark_addr != '0);

    // Entry 0 is never addressed by a write or mark, so its flops hold the reset zero.
    always_ff @(posedge clk) begin
        if (clr) begin
            mem  <= '0;
            busy <= '0;
        end else begin
            if (wr_hit) begin
                mem[bus.waddr]  <= bus.wdata;
                busy[bus.waddr] <= 1'b0;
            end
            // Later assignment wins: a new producer issued on the same edge keeps the entry busy.
            if (mk_hit)
                busy[bus.mark_addr] <= 1'b1;
        end
    end

    logic [NPORT-1:0][ADDR_BITS-1:0] ra;
    logic [NPORT-1:0][WIDTH-1:0]     rd;
    logic [NPORT-1:0]                rb;

    assign ra = {bus.raddr_b, bus.raddr_a};

    for (genvar p = 0; p < NPORT; p++) begin : g_rd
        always_comb begin
            rd[p] = mem[ra[p]];
            if ((BYPASS != 0) && wr_hit && (bus.waddr == ra[p]))
                rd[p] = bus.wdata;
            if (ra[p] == '0)
                rd[p] = '0;
        end
        // Busy reflects registered state only; a same-cycle write does not clear it early.
        assign rb[p] = busy[ra[p]];
    end

    assign bus.rdata_a  = rd[0];
    assign bus.rdata_b  = rd[1];
    assign bus.busy_a   = rb[0];
    assign bus.busy_b   = rb[1];
    assign bus.any_busy = |busy;
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-entry register file for the pipelined processor, built as the successor to the fixed 5-bit enabled register. It stores DEPTH words of WIDTH bits, with one synchronous write port and two combinational read ports. Entry 0 is hardwired to zero. An optional write-to-read bypass and a per-entry busy scoreboard let the decode stage detect hazards on multi-cycle (mult/div) results.

## Interface
- WIDTH, 32, data width in bits (≥1)
- ADDR_BITS, 5, address width; DEPTH = 2**ADDR_BITS entries
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads show stored value only

Ports (clock and reset first):
- clk  input  1  rising-edge clock; the only clock
- clr  input  1  synchronous, active-high reset
- we  input  1  write enable
- waddr  input  ADDR_BITS  write address
- wdata  input  WIDTH  write data
- mark_en  input  1  set busy bit of mark_addr (pending long-latency write)
- mark_addr  input  ADDR_BITS  entry to mark busy
- raddr_a, raddr_b  input  ADDR_BITS  read addresses
- rdata_a, rdata_b  output  WIDTH  read data, combinational
- busy_a, busy_b  output  1  busy bit of raddr_a / raddr_b, combinational
- any_busy  output  1  OR of all busy bits

## Operation
- Storage: DEPTH×WIDTH flops, each enabled only on a write to its own address.
- Write: on a rising clk edge with we=1 and waddr≠0, the entry is updated to wdata. Writes to entry 0 are discarded.
- Read: rdata_x = 0 when raddr_x=0. Otherwise:
  - If BYPASS=1, we=1 and waddr=raddr_x (≠0): rdata_x = wdata.
  - Otherwise: rdata_x = stored entry.
- Both ports may read the same address; results are identical.
- Scoreboard, one busy bit per entry, updated at the clock edge:
  - mark_en=1 and mark_addr≠0: busy[mark_addr] is set.
  - we=1 and waddr≠0: busy[waddr] is cleared.
  - Same edge, mark_addr = waddr: set wins, so the bit stays busy (a new producer has been issued).
  - Different addresses: both actions take effect.
  - busy[0] is constant 0; marks to entry 0 are ignored.
- busy_x = busy[raddr_x]. It reflects the registered state only; it is not bypassed by a same-cycle write.
- Reset: clr=1 at a rising edge clears all entries and all busy bits. clr overrides we and mark_en in the same cycle. Reset is sampled only at clk edges; mid-operation assertion takes effect at the next edge, and in-flight pending writes are simply lost.

## Timing
- Write latency: 1 edge. Data written at edge N is readable from the stored array after edge N.
  - BYPASS=1: also visible combinationally during the write cycle.
  - BYPASS=0: not visible until the cycle after the edge.
- Read latency: 0 cycles, pure combinational path from raddr/we/waddr/wdata.
- Busy set or clear: visible on busy_x one cycle after the edge.
- Reset values after a clr edge: every entry 0, rdata_a = rdata_b = 0, busy_a = busy_b = any_busy = 0.
- No handshake. Inputs are sampled every edge and there are no stall conditions.

## Test plan
- Reset: write 0xDEADBEEF to entry 7, assert clr for one edge, read entry 7 -> rdata = 0, any_busy = 0.
- Write and read: write 0x12345678 to entry 3; next cycle raddr_a = raddr_b = 3 -> both ports read 0x12345678. Write 0xFFFFFFFF to entry 0 -> entry 0 still reads 0.
- Bypass:
  - BYPASS=1: entry 5 holds 0x11; in the same cycle we=1, waddr=5, wdata=0x22, raddr_a=5 -> rdata_a = 0x22.
  - BYPASS=0, same stimulus -> rdata_a = 0x11, then 0x22 the next cycle.
- Scoreboard: mark entry 9 -> busy_a (raddr_a=9) = 1 and any_busy = 1 next cycle. Write entry 9 -> busy_a = 0 next cycle. Mark entry 0 -> busy stays 0.
- Simultaneous events:
  - mark_en and we to entry 4 on the same edge -> busy stays 1 and data is updated.
  - clr with we=1 and mark_en=1 -> all entries 0 and no busy bits.
- Width sweep: WIDTH=8, ADDR_BITS=3; write 0xA5 to all 7 writable entries, read each back -> 0xA5, entry 0 reads 0x00.
